bcd_converter: RTL and testbench

Sequential binary-to-packed-BCD converter (shift-add-3 / double dabble) that produces the 32-bit, 8-digit value consumed by the seven-segment display manager. It sits directly upstream of the display stage: counters and arithmetic blocks hand it an unsigned binary value with a start pulse. It returns eight BCD nibbles, digit 0 in bits [3:0], and holds them stable until the next conversion completes.

---
 rtl/bcd_converter.sv | 125 ++++++++++++
 tb/tb_bcd_converter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_converter.sv
// bcd_converter: sequential binary to 8-digit packed BCD (shift-add-3).
//
// Ports
//   bcd_converter_clk      in   system clock, rising edge
//   bcd_converter_rst      in   asynchronous active-high reset
//   bcd_converter_start    in   conversion request, accepted in IDLE/DONE
//   bcd_converter_bin      in   unsigned binary value [BIN_WIDTH-1:0]
//   bcd_converter_busy     out  conversion in progress (SHIFT)
//   bcd_converter_done     out  one-cycle pulse, new result loaded
//   bcd_converter_overflow out  last accepted value exceeded 99_999_999
//   bcd_converter_bcd      out  packed BCD, nibble k = decimal digit k
//
// Values above eight decimal digits skip the shift loop and saturate to
// all nines in a single edge. Normal conversions take BIN_WIDTH edges.

// Per-digit correction: bump a nibble by 3 when it is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_converter_digit (
  input  logic [3:0] nib,
  output logic [3:0] adj
);
  assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;
endmodule

module bcd_converter #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 bcd_converter_clk,
  input  logic                 bcd_converter_rst,
  input  logic                 bcd_converter_start,
  input  logic [BIN_WIDTH-1:0] bcd_converter_bin,
  output logic                 bcd_converter_busy,
  output logic                 bcd_converter_done,
  output logic                 bcd_converter_overflow,
  output logic [31:0]          bcd_converter_bcd
);

  localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
  localparam logic [31:0] MAX_DEC = 32'd99_999_999;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] bin_sr;
  logic [31:0]          work;
  logic [31:0]          work_adj;
  logic [31:0]          work_shift;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 ovf_in;
  logic                 last;

  // Eight independent nibble correctors; no carry between digits.
  bcd_converter_digit u_dig [7:0] (
    .nib (work),
    .adj (work_adj)
  );

  // {work, bin_sr} << 1 after correction: the binary MSB enters work[0].
  assign work_shift = (work_adj << 1) | 32'(bin_sr[BIN_WIDTH-1]);

  assign accept = (state != SHIFT) && bcd_converter_start;
  assign ovf_in = 32'(bcd_converter_bin) > MAX_DEC;
  // Counter value 1 marks the final of BIN_WIDTH shift iterations.
  assign last   = (state == SHIFT) && (cnt == CNT_W'(1));

  // State register
  always_ff @(posedge bcd_converter_clk or posedge bcd_converter_rst) begin
    if (bcd_converter_rst) state <= IDLE;
    else                   state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (bcd_converter_start) state_nxt = ovf_in ? DONE : SHIFT;
        else                     state_nxt = IDLE;
      end
      SHIFT:   state_nxt = last ? DONE : SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bcd_converter_busy = 1'b0;
    bcd_converter_done = 1'b0;
    case (state)
      SHIFT:   bcd_converter_busy = 1'b1;
      DONE:    bcd_converter_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: result/overflow only change on the edge that enters DONE.
  always_ff @(posedge bcd_converter_clk or posedge bcd_converter_rst) begin
    if (bcd_converter_rst) begin
      bin_sr                 <= '0;
      work                   <= '0;
      cnt                    <= '0;
      bcd_converter_bcd      <= '0;
      bcd_converter_overflow <= 1'b0;
    end else if (accept) begin
      if (ovf_in) begin
        bcd_converter_bcd      <= 32'h9999_9999;
        bcd_converter_overflow <= 1'b1;
      end else begin
        bin_sr <= bcd_converter_bin;
        work   <= '0;
        cnt    <= CNT_W'(BIN_WIDTH);
      end
    end else if (state == SHIFT) begin
      work   <= work_shift;
      bin_sr <= bin_sr << 1;
      cnt    <= cnt - CNT_W'(1);
      if (last) begin
        bcd_converter_bcd      <= work_shift;
        bcd_converter_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_converter.sv
// Directed bench for bcd_converter with a result scoreboard: expected
// results are queued when a conversion is launched and popped on done.
module tb_bcd_converter;

  typedef struct packed {
    logic [31:0] bcd;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic        busy, done, ovf;
  logic [31:0] bcd;

  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  res_t sb[$];

  bcd_converter #(.BIN_WIDTH(27)) dut (
    .bcd_converter_clk      (clk),
    .bcd_converter_rst      (rst),
    .bcd_converter_start    (start),
    .bcd_converter_bin      (bin),
    .bcd_converter_busy     (busy),
    .bcd_converter_done     (done),
    .bcd_converter_overflow (ovf),
    .bcd_converter_bcd      (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by division, saturating above 8 digits.
  function automatic res_t model(input logic [26:0] v);
    res_t r;
    int   x;
    x = int'(v);
    if (x > 99_999_999) begin
      r.bcd = 32'h9999_9999;
      r.ovf = 1'b1;
    end else begin
      r.bcd = '0;
      r.ovf = 1'b0;
      for (int k = 0; k < 8; k++) begin
        r.bcd[4*k +: 4] = 4'(x % 10);
        x = x / 10;
      end
    end
    return r;
  endfunction

  // Scoreboard consumer and busy/done exclusivity monitor.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          res_t e;
          e = sb.pop_front();
          chk("sb_bcd", 64'(bcd), 64'(e.bcd));
          chk("sb_ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
  end

  // Pulse start for one edge; returns 1 time unit after the accepting edge.
  task automatic start_conv(input logic [26:0] v, input bit push);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    if (push) sb.push_back(model(v));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges until done is seen (sampled 1 unit after each edge), bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n, n2, dc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf",  64'(ovf),  64'd0);
    chk("rst_bcd",  64'(bcd),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Zero
    start_conv(27'd0, 1'b1);
    chk("zero_busy", 64'(busy), 64'd1);
    wait_done(n);
    chk("zero_lat", 64'(n), 64'd27);
    chk("zero_bcd", 64'(bcd), 64'h0);

    // Typical value, done is one cycle wide, result holds
    start_conv(27'd12_345_678, 1'b1);
    wait_done(n);
    chk("mid_lat", 64'(n), 64'd27);
    chk("mid_busy_at_done", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    chk("mid_done_width", 64'(done), 64'd0);
    dc = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    chk("mid_hold_bcd", 64'(bcd), 64'h1234_5678);
    chk("mid_hold_nodone", 64'(done_cnt), 64'(dc));

    // Largest in-range value, then first overflowing value
    start_conv(27'd99_999_999, 1'b1);
    wait_done(n);
    chk("max_lat", 64'(n), 64'd27);
    chk("max_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    start_conv(27'd100_000_000, 1'b1);
    chk("ovf_done_e0", 64'(done), 64'd1);
    chk("ovf_busy", 64'(busy), 64'd0);
    chk("ovf_bcd", 64'(bcd), 64'h9999_9999);
    chk("ovf_flag", 64'(ovf), 64'd1);
    @(posedge clk);
    #1;
    chk("ovf_busy_after", 64'(busy), 64'd0);
    chk("ovf_done_drop", 64'(done), 64'd0);

    // Start during SHIFT is dropped
    start_conv(27'd5, 1'b1);
    chk("ign_ovf_hold", 64'(ovf), 64'd1);
    dc = done_cnt;
    repeat (9) @(posedge clk);
    start_conv(27'd77, 1'b0);
    wait_done(n);
    chk("ign_lat", 64'(n), 64'd17);
    repeat (40) @(posedge clk);
    #1;
    chk("ign_bcd", 64'(bcd), 64'h5);
    chk("ign_one_done", 64'(done_cnt - dc), 64'd1);

    // Reset mid-SHIFT aborts without a done pulse
    start_conv(27'd4_096, 1'b0);
    dc = done_cnt;
    repeat (12) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_bcd", 64'(bcd), 64'h0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("abort_nodone", 64'(done_cnt), 64'(dc));
    start_conv(27'd4_096, 1'b1);
    wait_done(n);
    chk("retry_bcd", 64'(bcd), 64'h4096);

    // Back-to-back: start held high across the DONE cycle
    repeat (2) @(posedge clk);
    @(negedge clk);
    bin   = 27'd9;
    start = 1'b1;
    sb.push_back(model(27'd9));
    @(posedge clk);
    #1;
    bin = 27'd10;
    wait_done(n);
    chk("b2b_lat1", 64'(n), 64'd27);
    sb.push_back(model(27'd10));
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_done_drop", 64'(done), 64'd0);
    chk("b2b_busy_rise", 64'(busy), 64'd1);
    wait_done(n2);
    chk("b2b_gap", 64'(n2 + 1), 64'd28);
    @(posedge clk);
    #1;
    chk("b2b_final", 64'(bcd), 64'h10);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
